// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge-detection pipeline stages.
// Gradient samples are unsigned magnitudes of DATA_WIDTH bits.
package canny_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic DIR_HORIZ = 1'b0;
  localparam logic DIR_VERT  = 1'b1;

endpackage : canny_pkg

// File: rtl/nms_compare.sv
// Combinational local-maximum test: passes the centre magnitude through when it
// is at least as large as both neighbours (ties kept), otherwise returns zero.
module nms_compare
  import canny_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic [W-1:0] centre,
  input  logic [W-1:0] nbr_a,
  input  logic [W-1:0] nbr_b,
  output logic [W-1:0] result
);

  always_comb begin
    // NOTE: assign a default before any condition so no path leaves result unassigned, which would infer a latch.
    result = '0;
    if ((centre >= nbr_a) && (centre >= nbr_b)) begin
      result = centre;
    end
  end

endmodule : nms_compare

// File: rtl/non_maxima_suppression.sv
// Non-maxima suppression along a 1-bit quantised gradient direction: selects the
// row or column neighbours of the centre pixel and registers the kept magnitude.
module non_maxima_suppression
  import canny_pkg::*;
#(
  parameter int DATA_WIDTH = canny_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p00,
  input  logic [DATA_WIDTH-1:0] p01,
  input  logic [DATA_WIDTH-1:0] p02,
  input  logic [DATA_WIDTH-1:0] p10,
  input  logic [DATA_WIDTH-1:0] p11,
  input  logic [DATA_WIDTH-1:0] p12,
  input  logic [DATA_WIDTH-1:0] p20,
  input  logic [DATA_WIDTH-1:0] p21,
  input  logic [DATA_WIDTH-1:0] p22,
  input  logic                  grad_dir,
  output logic [DATA_WIDTH-1:0] edge_out
);

  logic [DATA_WIDTH-1:0] nbr_a;
  logic [DATA_WIDTH-1:0] nbr_b;
  logic [DATA_WIDTH-1:0] edge_d;
  logic [DATA_WIDTH-1:0] edge_q;

  // Diagonals are reserved for a four-direction variant; reduced here only so
  // they are visibly consumed, and this net feeds nothing.
  logic unused_diag;
  assign unused_diag = ^{p00, p02, p20, p22};

  always_comb begin
    nbr_a = p10;
    nbr_b = p12;
    if (grad_dir == DIR_VERT) begin
      nbr_a = p01;
      nbr_b = p21;
    end
  end

  nms_compare #(
    .W (DATA_WIDTH)
  ) u_compare (
    .centre (p11),
    .nbr_a  (nbr_a),
    .nbr_b  (nbr_b),
    .result (edge_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

  assign edge_out = edge_q;

endmodule : non_maxima_suppression

// File: tb/tb_non_maxima_suppression.sv
// Self-checking bench for non_maxima_suppression: directed corner cases, async
// reset behaviour and a full 256x256 zero-padded image streamed one pixel/clock.
module tb_non_maxima_suppression;
  import canny_pkg::*;

  localparam int W    = canny_pkg::DATA_WIDTH;
  localparam int IMG  = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic         grad_dir;
  logic [W-1:0] edge_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] img [IMG][IMG];

  non_maxima_suppression #(
    .DATA_WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p00      (p00),
    .p01      (p01),
    .p02      (p02),
    .p10      (p10),
    .p11      (p11),
    .p12      (p12),
    .p20      (p20),
    .p21      (p21),
    .p22      (p22),
    .grad_dir (grad_dir),
    .edge_out (edge_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: edge_out=0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the centre survives when it is no smaller than the larger of the
  // two neighbours lying along the gradient direction.
  function automatic logic [W-1:0] ref_nms(input int c, input int left, input int right,
                                           input int up, input int down, input logic dir);
    int biggest;
    if (dir == DIR_VERT) biggest = (up > down) ? up : down;
    else                 biggest = (left > right) ? left : right;
    return (c >= biggest) ? W'(c) : '0;
  endfunction

  function automatic logic [W-1:0] pix(input int r, input int c);
    if (r < 0 || r >= IMG || c < 0 || c >= IMG) return '0;
    return img[r][c];
  endfunction

  task automatic set_win(input logic [W-1:0] c, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic [W-1:0] u, input logic [W-1:0] d, input logic [W-1:0] diag,
                         input logic dir);
    p11 = c;  p10 = l;  p12 = r;  p01 = u;  p21 = d;
    p00 = diag; p02 = diag; p20 = diag; p22 = diag;
    grad_dir = dir;
  endtask

  // Inputs change 1 time unit after a rising edge, output sampled 1 unit after the next.
  task automatic apply(input string tag, input logic [W-1:0] c, input logic [W-1:0] l,
                       input logic [W-1:0] r, input logic [W-1:0] u, input logic [W-1:0] d,
                       input logic [W-1:0] diag, input logic dir, input logic [W-1:0] exp);
    set_win(c, l, r, u, d, diag, dir);
    @(posedge clk);
    #1;
    check(tag, edge_out, exp);
  endtask

  initial begin
    rst = 1'b1;
    set_win(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, DIR_HORIZ);
    #2;
    check("reset_initial", edge_out, 8'h00);

    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", edge_out, 8'h80);

    // Mid-stream reset must clear the output without waiting for an edge.
    rst = 1'b1;
    #1;
    check("reset_async", edge_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held", edge_out, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_rerelease", edge_out, 8'h80);

    apply("h_max",      8'h50, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'h00, DIR_HORIZ, 8'h50);
    apply("h_suppress", 8'h50, 8'h60, 8'h10, 8'h10, 8'h40, 8'h00, DIR_HORIZ, 8'h00);
    apply("v_keep",     8'h50, 8'h60, 8'h10, 8'h10, 8'h40, 8'h00, DIR_VERT,  8'h50);
    apply("v_tie",      8'h50, 8'hFF, 8'hFF, 8'h50, 8'h50, 8'h00, DIR_VERT,  8'h50);
    apply("v_suppress", 8'h50, 8'hFF, 8'hFF, 8'h50, 8'h51, 8'h00, DIR_VERT,  8'h00);
    apply("h_tie_left", 8'h33, 8'h33, 8'h00, 8'hFF, 8'hFF, 8'h00, DIR_HORIZ, 8'h33);
    apply("h_right_up", 8'h33, 8'h00, 8'h34, 8'h00, 8'h00, 8'h00, DIR_HORIZ, 8'h00);
    apply("diag_ff",    8'h50, 8'h20, 8'h30, 8'h00, 8'h00, 8'hFF, DIR_HORIZ, 8'h50);
    apply("diag_ff_v",  8'h50, 8'h00, 8'h00, 8'h60, 8'h00, 8'hFF, DIR_VERT,  8'h00);
    apply("all_max_h",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, DIR_HORIZ, 8'hFF);
    apply("all_max_v",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, DIR_VERT,  8'hFF);
    apply("zero_centre",8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, DIR_HORIZ, 8'h00);
    apply("zero_diag",  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, DIR_VERT,  8'h00);

    // Mix coarse levels (frequent ties) with full-range values.
    for (int r = 0; r < IMG; r++) begin
      for (int c = 0; c < IMG; c++) begin
        if ((r / 16) % 2 == 0) img[r][c] = W'($urandom_range(0, 7) * 32);
        else                   img[r][c] = W'($urandom_range(0, 255));
      end
    end

    for (int r = 0; r < IMG; r++) begin
      for (int c = 0; c < IMG; c++) begin
        logic         dir;
        logic [W-1:0] diag;
        logic [W-1:0] exp;
        dir  = logic'($urandom_range(0, 1));
        diag = ($urandom_range(0, 1) == 1) ? 8'hFF : W'($urandom_range(0, 255));
        exp  = ref_nms(int'(pix(r, c)), int'(pix(r, c - 1)), int'(pix(r, c + 1)),
                       int'(pix(r - 1, c)), int'(pix(r + 1, c)), dir);
        apply("stream", pix(r, c), pix(r, c - 1), pix(r, c + 1),
              pix(r - 1, c), pix(r + 1, c), diag, dir, exp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_non_maxima_suppression
